// File: rtl/uop_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: uOP codes, store entry layout, FSM states.
package uop_sequencer_pkg;

  localparam int unsigned UOP_W   = 5;
  localparam int unsigned ENTRY_W = 6;
  localparam int unsigned END_BIT = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [UOP_W-1:0] UOP_RST = 5'b00000;
  localparam logic [UOP_W-1:0] UOP_LDM = 5'b00001;
  localparam logic [UOP_W-1:0] UOP_LDQ = 5'b00010;
  localparam logic [UOP_W-1:0] UOP_MUL = 5'b10110;
  localparam logic [UOP_W-1:0] UOP_MAX = 5'b10110;

  // Store entry: END flag in bit 5, uOP in bits 4:0.
  typedef struct packed {
    logic             end_f;
    logic [UOP_W-1:0] uop;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_MULHOLD = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/uop_store.sv
// Writable micro-program store: DEPTH entries, one write port, one combinational read port.
module uop_store
  import uop_sequencer_pkg::*;
#(
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: issues one uOP per clock from a writable store, holds the
// multiply uOP for MUL_CYCLES cycles and reports normal completion (DONE) or abort (ERR).
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int unsigned AW         = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MUL_CYCLES = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWE,
  input  logic [AW-1:0]    PWADDR,
  input  logic [5:0]       PWDATA,
  input  logic             START,
  input  logic [AW-1:0]    START_ADDR,
  output logic [UOP_W-1:0] UOP,
  output logic             UOP_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [AW-1:0]    PC_LAST  = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t              state, state_nx;
  logic [AW-1:0]       pc, pc_nx;
  logic [CNT_W-1:0]    mul_cnt, mul_cnt_nx;
  entry_t              ent0_q, ent0_nx;
  logic                first_q, first_nx;
  logic                mul_end_q, mul_end_nx;
  logic                abort_q, abort_nx;
  logic [UOP_W-1:0]    uop_nx;
  logic                uop_valid_nx, busy_nx, done_nx, err_nx;

  entry_t              rd_ent, cur_ent;
  logic [AW-1:0]       rd_addr;
  logic                illegal, is_mul, pc_last, mul_last;

  // In IDLE the read port looks at START_ADDR so the first entry can be captured at the
  // START edge, before any same-cycle write lands in the store.
  assign rd_addr  = (state == ST_IDLE) ? START_ADDR : pc;
  assign cur_ent  = first_q ? ent0_q : rd_ent;
  assign illegal  = cur_ent.uop > UOP_MAX;
  assign is_mul   = cur_ent.uop == UOP_MUL;
  assign pc_last  = pc == PC_LAST;
  assign mul_last = mul_cnt == MUL_LAST;

  uop_store #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_store (
    .CLK   (CLK),
    .we    (PWE && (state == ST_IDLE)),
    .waddr (PWADDR),
    .wdata (entry_t'(PWDATA)),
    .raddr (rd_addr),
    .rdata (rd_ent)
  );

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      pc        <= '0;
      mul_cnt   <= '0;
      ent0_q    <= '0;
      first_q   <= 1'b0;
      mul_end_q <= 1'b0;
      abort_q   <= 1'b0;
      UOP       <= UOP_RST;
      UOP_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      mul_cnt   <= mul_cnt_nx;
      ent0_q    <= ent0_nx;
      first_q   <= first_nx;
      mul_end_q <= mul_end_nx;
      abort_q   <= abort_nx;
      UOP       <= uop_nx;
      UOP_VALID <= uop_valid_nx;
      BUSY      <= busy_nx;
      DONE      <= done_nx;
      ERR       <= err_nx;
    end
  end

  // Next-state logic; an abort at the last entry also exits through FINISH
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (START) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (illegal)                          state_nx = ST_IDLE;
        else if (is_mul)                      state_nx = ST_MULHOLD;
        else if (cur_ent.end_f || pc_last)    state_nx = ST_FINISH;
      end
      ST_MULHOLD: begin
        if (mul_last) state_nx = (mul_end_q || pc_last) ? ST_FINISH : ST_ISSUE;
      end
      ST_FINISH:  state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_nx        = pc;
    mul_cnt_nx   = mul_cnt;
    ent0_nx      = ent0_q;
    first_nx     = 1'b0;
    mul_end_nx   = mul_end_q;
    abort_nx     = abort_q;
    uop_nx       = UOP;
    uop_valid_nx = UOP_VALID;
    busy_nx      = BUSY;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        uop_nx       = UOP_RST;
        uop_valid_nx = 1'b0;
        busy_nx      = START;
        if (START) begin
          pc_nx    = START_ADDR;
          ent0_nx  = rd_ent;
          first_nx = 1'b1;
          abort_nx = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (illegal) begin
          uop_nx       = UOP_RST;
          uop_valid_nx = 1'b0;
          busy_nx      = 1'b0;
          err_nx       = 1'b1;
        end else begin
          uop_nx       = cur_ent.uop;
          uop_valid_nx = 1'b1;
          if (is_mul) begin
            mul_cnt_nx = CNT_W'(1);
            mul_end_nx = cur_ent.end_f;
          end else if (!cur_ent.end_f) begin
            if (pc_last) abort_nx = 1'b1;
            else         pc_nx    = pc + AW'(1);
          end
        end
      end
      ST_MULHOLD: begin
        // The ISSUE cycle presents the first copy; MULHOLD supplies the remaining ones.
        uop_nx       = UOP_MUL;
        uop_valid_nx = 1'b1;
        mul_cnt_nx   = mul_cnt + CNT_W'(1);
        if (mul_last && !mul_end_q) begin
          if (pc_last) abort_nx = 1'b1;
          else         pc_nx    = pc + AW'(1);
        end
      end
      ST_FINISH: begin
        uop_nx       = UOP_RST;
        uop_valid_nx = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = !abort_q;
        err_nx       = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed self-checking bench for uop_sequencer: programs, multiply hold, aborts, reset.
module tb_uop_sequencer;

  localparam int unsigned AW         = 4;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned MUL_CYCLES = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PWE = 1'b0;
  logic [AW-1:0] PWADDR = '0;
  logic [5:0]    PWDATA = '0;
  logic          START = 1'b0;
  logic [AW-1:0] START_ADDR = '0;
  logic [4:0]    UOP;
  logic          UOP_VALID, BUSY, DONE, ERR;

  int n_cmp = 0;
  int n_err = 0;

  uop_sequencer #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PWE        (PWE),
    .PWADDR     (PWADDR),
    .PWDATA     (PWDATA),
    .START      (START),
    .START_ADDR (START_ADDR),
    .UOP        (UOP),
    .UOP_VALID  (UOP_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compares {UOP, UOP_VALID, BUSY, DONE, ERR} against expected values
  task automatic out(input string tag, input logic [4:0] u, input logic v,
                     input logic b, input logic d, input logic e);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {UOP, UOP_VALID, BUSY, DONE, ERR};
    exp = {u, v, b, d, e};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: uop_v_b_d_e observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pwrite(input logic [AW-1:0] a, input logic [5:0] d);
    PWADDR = a;
    PWDATA = d;
    PWE    = 1'b1;
    tick();
    PWE    = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] a);
    START_ADDR = a;
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  // Program A at address 0: 00001, 00010, 00110|END
  task automatic run_a(input string tag);
    start(4'd0);
    out({tag, "_start"}, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); out({tag, "_u0"}, 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out({tag, "_u1"}, 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out({tag, "_u2"}, 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out({tag, "_done"}, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); out({tag, "_idle"}, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 RST = 1'b1;
    #1 out("reset_async", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    tick();

    pwrite(4'd0, 6'b000001);
    pwrite(4'd1, 6'b000010);
    pwrite(4'd2, 6'b100110);
    run_a("prog_a");

    // Multiply program: 00001, 10110 held MUL_CYCLES, 00100|END
    pwrite(4'd4, 6'b000001);
    pwrite(4'd5, 6'b010110);
    pwrite(4'd6, 6'b100100);
    start(4'd4);
    out("mul_start", 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); out("mul_u0", 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(MUL_CYCLES); i++) begin
      tick(); out($sformatf("mul_hold%0d", i), 5'b10110, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick(); out("mul_u2", 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("mul_done", 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);

    // START and PWE while busy are ignored
    start(4'd0);
    PWADDR = 4'd1; PWDATA = 6'b000101; PWE = 1'b1;
    START_ADDR = 4'd4; START = 1'b1;
    out("busy_start", 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); out("busy_u0", 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    PWE = 1'b0; START = 1'b0;
    tick(); out("busy_u1", 5'b00010, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("busy_u2", 5'b00110, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("busy_done", 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    run_a("store_kept");

    // Reset during multiply hold aborts without DONE/ERR
    start(4'd4);
    tick(); out("rstmul_u0", 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("rstmul_hold", 5'b10110, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #2 RST = 1'b1;
    #1 out("rstmul_async", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 RST = 1'b0;
    tick(); out("rstmul_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); out("rstmul_idle2", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_a("after_rst");

    // Illegal uOP aborts
    pwrite(4'd1, 6'b011000);
    start(4'd0);
    tick(); out("ill_u0", 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("ill_err", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); out("ill_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Last entry without END aborts; PC must not wrap to entry 0
    pwrite(4'd15, 6'b000011);
    start(4'd15);
    tick(); out("wrap_u0", 5'b00011, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("wrap_err", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); out("wrap_idle", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Same-cycle write and START: the old entry runs, the new one lands
    PWADDR = 4'd0; PWDATA = 6'b000011; PWE = 1'b1;
    START_ADDR = 4'd0; START = 1'b1;
    tick();
    PWE = 1'b0; START = 1'b0;
    tick(); out("wrst_old", 5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("wrst_err", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    start(4'd0);
    tick(); out("wrst_new", 5'b00011, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); out("wrst_err2", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
